// File: rtl/cbus_ram_responder.sv
// cbus_ram_responder: word-addressed 64-bit RAM answering cbus single/burst requests after LATENCY idle cycles.
// Define CBUS_RAM_RANDOM_STALL_EN to insert LFSR-driven stall cycles between burst beats.
module cbus_ram_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        creq_valid,
    input  logic        creq_is_write,
    input  logic [2:0]  creq_size,
    input  logic [31:0] creq_addr,
    input  logic [7:0]  creq_strobe,
    input  logic [63:0] creq_data,
    input  logic [3:0]  creq_len,
    input  logic [1:0]  creq_burst,
    output logic        cresp_ready,
    output logic        cresp_last,
    output logic [63:0] cresp_data
);
    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;
    localparam logic [3:0] LAT        = 4'(LATENCY);
    localparam logic [1:0] BURST_INCR = 2'b01;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d, idx;
    logic                  is_write_q, is_write_d, incr_q, incr_d;
    logic [3:0]            len_q, len_d, beat_q, beat_d, lat_q, lat_d;
    logic [63:0]           mem [2**ADDR_WIDTH];
    logic                  stall, wr_en, unused_ok;

    // Size only shapes the strobe upstream; byte offset and upper address bits alias away.
    assign unused_ok = ^{creq_size, creq_addr[31:ADDR_WIDTH+3], creq_addr[2:0]};
    assign idx       = base_q + (incr_q ? ADDR_WIDTH'(beat_q) : '0);

`ifdef CBUS_RAM_RANDOM_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;
    assign lfsr_d = (state_q == BURST) ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
    assign stall  = (state_q == BURST) && lfsr_q[0];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= 8'hA5;
        else        lfsr_q <= lfsr_d;
    end
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        is_write_d  = is_write_q;
        incr_d      = incr_q;
        len_d       = len_q;
        beat_d      = beat_q;
        lat_d       = lat_q;
        cresp_ready = 1'b0;
        cresp_last  = 1'b0;
        cresp_data  = '0;
        wr_en       = 1'b0;
        case (state_q)
            IDLE: if (creq_valid) begin
                base_d     = creq_addr[ADDR_WIDTH+2:3];
                is_write_d = creq_is_write;
                incr_d     = creq_burst == BURST_INCR;
                len_d      = creq_len;
                beat_d     = '0;
                lat_d      = LAT;
                state_d    = (LAT == 4'd0) ? BURST : WAIT;
            end
            WAIT: begin
                lat_d   = lat_q - 4'd1;
                state_d = (lat_q <= 4'd1) ? BURST : WAIT;
            end
            BURST: if (!stall) begin
                cresp_ready = 1'b1;
                cresp_last  = beat_q == len_q;
                cresp_data  = is_write_q ? '0 : mem[idx];
                wr_en       = is_write_q;
                beat_d      = beat_q + 4'd1;
                state_d     = cresp_last ? DONE : BURST;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            is_write_q <= 1'b0;
            incr_q     <= 1'b0;
            len_q      <= '0;
            beat_q     <= '0;
            lat_q      <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            is_write_q <= is_write_d;
            incr_q     <= incr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            lat_q      <= lat_d;
        end
    end

    // Backing store is deliberately not reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (creq_strobe[b]) mem[idx][8*b +: 8] <= creq_data[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_cbus_ram_responder.sv
// tb_cbus_ram_responder: randomized + directed bench for cbus_ram_responder against a
// transaction-level model (beat schedule from accept cycle, byte-mask tracked RAM image).
module tb_cbus_ram_responder;
    localparam int AW  = 10;
    localparam int LAT = 2;
    localparam int NW  = 2**AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        creq_valid, creq_is_write;
    logic [2:0]  creq_size;
    logic [31:0] creq_addr;
    logic [7:0]  creq_strobe;
    logic [63:0] creq_data;
    logic [3:0]  creq_len;
    logic [1:0]  creq_burst;
    logic        cresp_ready, cresp_last;
    logic [63:0] cresp_data;

    cbus_ram_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
        .creq_addr(creq_addr), .creq_strobe(creq_strobe), .creq_data(creq_data),
        .creq_len(creq_len), .creq_burst(creq_burst),
        .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0;
    logic [63:0] mem_m [NW];
    logic [7:0]  mem_v [NW];
    logic [63:0] bd [16];
    logic [7:0]  bs [16];
    logic [63:0] cap [$];
    logic        chk_en = 1'b0, exp_ready = 1'b0, exp_last = 1'b0;
    logic [63:0] exp_data = '0, exp_mask = '1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp, input logic [63:0] mask);
        n_chk++;
        if (((act ^ exp) & mask) !== 64'd0) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h (mask %h)", name, $time, act, exp, mask);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 64'(cresp_ready), 64'(exp_ready), '1);
            check("last", 64'(cresp_last), 64'(exp_last), '1);
            check("data", cresp_data, exp_data, exp_mask);
            if (cresp_ready) cap.push_back(cresp_data);
        end
    end

    task automatic junk();
        creq_is_write = 1'($urandom);
        creq_size     = 3'($urandom);
        creq_addr     = $urandom;
        creq_strobe   = 8'($urandom);
        creq_data     = {$urandom, $urandom};
        creq_len      = 4'($urandom);
        creq_burst    = 2'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            creq_valid = 1'b0;
            junk();
            exp_ready = 1'b0; exp_last = 1'b0; exp_data = '0; exp_mask = '1;
            @(posedge clk); #1;
        end
    endtask

    // One transaction, driven from its accept cycle through the DONE turnaround.
    // rst_beat >= 0 pulses reset during that beat and abandons the rest.
    task automatic txn(input bit wr, input logic [31:0] addr, input int len, input bit incr,
                       input bit hold, input int rst_beat);
        int base;
        base = int'(addr[AW+2:3]);
        cap.delete();
        for (int c = 0; c <= LAT + len + 2; c++) begin
            int  k, idx;
            bit  beat, rst;
            k    = c - 1 - LAT;
            beat = (k >= 0) && (k <= len);
            idx  = beat ? (base + (incr ? k : 0)) % NW : 0;
            rst  = beat && (k == rst_beat);
            junk();
            creq_valid = (c == 0) || hold;
            if (c == 0) begin
                creq_is_write = wr; creq_addr = addr; creq_len = 4'(len);
                creq_burst = incr ? 2'b01 : 2'b00;
            end
            if (beat) begin
                creq_data = bd[k]; creq_strobe = bs[k];
            end
            if (rst) reset = 1'b0;
            exp_ready = beat && !rst;
            exp_last  = beat && !rst && (k == len);
            exp_data  = (beat && !rst && !wr) ? mem_m[idx] : '0;
            exp_mask  = '1;
            if (beat && !rst && !wr)
                for (int b = 0; b < 8; b++) exp_mask[8*b +: 8] = {8{mem_v[idx][b]}};
            @(posedge clk);
            if (beat && wr && !rst)
                for (int b = 0; b < 8; b++)
                    if (bs[k][b]) begin
                        mem_m[idx][8*b +: 8] = bd[k][8*b +: 8];
                        mem_v[idx][b] = 1'b1;
                    end
            #1;
            if (rst) begin
                reset = 1'b1;
                break;
            end
        end
    endtask

    task automatic fill(input logic [63:0] start, input logic [7:0] strb);
        for (int i = 0; i < 16; i++) begin
            bd[i] = start + 64'(i);
            bs[i] = strb;
        end
    endtask

    initial begin
        logic [31:0] tmp;
        int          widx;
        for (int i = 0; i < NW; i++) begin
            mem_m[i] = '0; mem_v[i] = '0;
        end
        reset = 1'b0;
        creq_valid = 1'b0;
        junk();
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        idle(2);

        fill(64'h1122334455667788, 8'hFF);
        txn(1, 32'h80000040, 0, 1, 0, -1);
        txn(0, 32'h80000040, 0, 1, 0, -1);
        check("rd_full", cap[0], 64'h1122334455667788, '1);
        fill(64'hFFFFFFFFAAAAAAAA, 8'h0F);
        txn(1, 32'h80000040, 0, 1, 0, -1);
        txn(0, 32'h80000040, 0, 1, 0, -1);
        check("rd_strobe", cap[0], 64'h11223344AAAAAAAA, '1);

        fill(64'd0, 8'hFF);
        txn(1, 32'h80001000, 15, 1, 1, -1);
        idle(1);
        txn(0, 32'h80001000, 15, 1, 0, -1);
        check("incr_beats", 64'(cap.size()), 64'd16, '1);
        for (int i = 0; i < 16; i++) check("incr_data", cap[i], 64'(i), '1);

        fill(64'h5A5A5A5A5A5A5A5A, 8'hFF);
        txn(1, 32'h80002008, 0, 1, 0, -1);
        fill(64'd1, 8'hFF);
        txn(1, 32'h80002000, 3, 0, 0, -1);
        txn(0, 32'h80002000, 0, 1, 0, -1);
        check("fixed_last", cap[0], 64'd4, '1);
        txn(0, 32'h80002008, 0, 1, 0, -1);
        check("fixed_nbr", cap[0], 64'h5A5A5A5A5A5A5A5A, '1);

        fill(64'hEE00, 8'hFF);
        txn(1, 32'h80003000, 15, 1, 0, -1);
        fill(64'hC0, 8'hFF);
        txn(1, 32'h80003000, 15, 1, 0, 5);
        idle(2);
        txn(0, 32'h80003000, 15, 1, 0, -1);
        check("rst_beats", 64'(cap.size()), 64'd16, '1);
        for (int i = 0; i < 16; i++)
            check("rst_data", cap[i], (i < 5) ? 64'hC0 + 64'(i) : 64'hEE00 + 64'(i), '1);

        repeat (80) begin
            tmp  = $urandom;
            widx = ($urandom_range(0, 3) == 0) ? $urandom_range(NW - 8, NW - 1) : $urandom_range(0, 47);
            for (int i = 0; i < 16; i++) begin
                bd[i] = {$urandom, $urandom};
                bs[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
            end
            txn(1'($urandom), {tmp[31:AW+3], AW'(widx), tmp[2:0]},
                ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15),
                1'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1);
            idle($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
